// File: rtl/tmac_pkg.sv
// Shared constants for the TMAC CPU register interface: register map,
// version word and per-channel FIFO event bit positions.
// Pure constants; no logic, no latency, no flow control.
package tmac_pkg;

  // Global register word addresses
  localparam int ADDR_VERSION  = 'h00;
  localparam int ADDR_CTRL     = 'h01;
  localparam int ADDR_INT_STAT = 'h02;
  localparam int ADDR_INT_MASK = 'h03;

  // Per-channel register block: channel c lives at CH_BASE + CH_STRIDE*c
  localparam int CH_BASE   = 'h10;
  localparam int CH_STRIDE = 4;

  localparam logic [1:0] CH_OFF_CTRL = 2'd0;
  localparam logic [1:0] CH_OFF_LEN  = 2'd1;
  localparam logic [1:0] CH_OFF_CNT  = 2'd2;

  // CH_CTRL bit positions
  localparam int CH_CTRL_RDI = 0;
  localparam int CH_CTRL_RTP = 1;
  localparam int CH_CTRL_COM = 2;

  localparam logic [15:0] VERSION = 16'h0201;

  // Bit index of each event inside a channel's 4-bit fifo_evt nibble
  localparam int EVT_BM_OVF   = 0;
  localparam int EVT_BM_UDF   = 1;
  localparam int EVT_TMAC_OVF = 2;
  localparam int EVT_TMAC_UDF = 3;

endpackage

// File: rtl/tmac_mpi_chreg.sv
// One channel's register block: CH_CTRL, TPKT_LEN, pkt_ind edge detect, PKT_CNT.
// Writes take effect at the strobe edge; outputs are registered (1 cycle).
// No backpressure: CPU strobes and pkt_ind are accepted every cycle.
//
// Ports:
//   clk100m, rst         clock, synchronous active-low reset
//   i_wr_ctrl/len/cnt    decoded write strobes for this channel's registers
//   i_wdat               low bits of the CPU write data
//   i_pkt_ind            "packet taken" indication from the datapath
//   o_rdi_en, o_rtp_en   channel enables
//   o_pkt_com            packet-complete flag
//   o_len                transmit packet length
//   o_cnt                saturating count of pkt_ind rising edges
module tmac_mpi_chreg
  import tmac_pkg::*;
#(
  parameter int LEN_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk100m,
  input  logic             rst,
  input  logic             i_wr_ctrl,
  input  logic             i_wr_len,
  input  logic             i_wr_cnt,
  input  logic [LEN_W-1:0] i_wdat,
  input  logic             i_pkt_ind,
  output logic             o_rdi_en,
  output logic             o_rtp_en,
  output logic             o_pkt_com,
  output logic [LEN_W-1:0] o_len,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_ind_d;
  logic             r_rdi;
  logic             r_rtp;
  logic             r_com;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;

  assign w_rise = i_pkt_ind & ~r_ind_d;

  always_ff @(posedge clk100m) begin
    if (!rst) begin
      r_ind_d <= 1'b0;
      r_rdi   <= 1'b0;
      r_rtp   <= 1'b0;
      r_com   <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_ind_d <= i_pkt_ind;

      if (i_wr_ctrl) begin
        r_rdi <= i_wdat[CH_CTRL_RDI];
        r_rtp <= i_wdat[CH_CTRL_RTP];
      end

      // CPU set beats the datapath's clear so a freshly queued packet is never lost
      if (i_wr_ctrl && i_wdat[CH_CTRL_COM]) begin
        r_com <= 1'b1;
      end else if (w_rise) begin
        r_com <= 1'b0;
      end

      if (i_wr_len) begin
        r_len <= i_wdat;
      end

      // A CPU clear beats a coincident increment; the count sticks at all-ones
      if (i_wr_cnt) begin
        r_cnt <= '0;
      end else if (w_rise && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rdi_en  = r_rdi;
  assign o_rtp_en  = r_rtp;
  assign o_pkt_com = r_com;
  assign o_len     = r_len;
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/tmac_mpi_nch.sv
// CPU register interface for an NCH-channel transmit MAC: globals, interrupts, read mux.
// Writes visible 1 cycle after the strobe; read data on cpu_dout 2 edges after the strobe.
// No backpressure: one CPU access per cycle is always accepted.
//
// Ports:
//   clk100m, rst                  clock, synchronous active-low reset
//   cpu_cs/wr/rd/addr/din/dout    CPU word bus (cpu_dout registered, held between reads)
//   cpu_int                       level or pulse interrupt (INT_PULSE)
//   pkt_ind, fifo_evt             per-channel datapath indications
//   ipg_th, rdi_en, rtp_en,
//   pkt_com, tpkt_length          register outputs to the datapaths
module tmac_mpi_nch
  import tmac_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int LEN_W     = 10,
  parameter int IPG_RST   = 12,
  parameter int INT_PULSE = 0,
  parameter int CNT_W     = 16   // PKT_CNT width; the register saturates at all-ones
) (
  input  logic                 clk100m,
  input  logic                 rst,
  input  logic                 cpu_cs,
  input  logic                 cpu_wr,
  input  logic                 cpu_rd,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_din,
  output logic [DW-1:0]        cpu_dout,
  output logic                 cpu_int,
  input  logic [NCH-1:0]       pkt_ind,
  input  logic [4*NCH-1:0]     fifo_evt,
  output logic [3:0]           ipg_th,
  output logic [NCH-1:0]       rdi_en,
  output logic [NCH-1:0]       rtp_en,
  output logic [NCH-1:0]       pkt_com,
  output logic [NCH*LEN_W-1:0] tpkt_length
);

  localparam int EW = 4 * NCH;

  logic             w_wr;
  logic             w_rd;
  logic             w_sel_ver;
  logic             w_sel_ctrl;
  logic             w_sel_stat;
  logic             w_sel_mask;
  logic             w_in_ch;
  logic [AW-1:0]    w_ch_rel;
  logic [1:0]       w_ch_off;
  logic [NCH-1:0]   w_ch_hit;
  logic [NCH-1:0]   w_rdi;
  logic [NCH-1:0]   w_rtp;
  logic [NCH-1:0]   w_com;
  logic [LEN_W-1:0] w_len [NCH];
  logic [CNT_W-1:0] w_cnt [NCH];
  logic [EW-1:0]    w_clr;
  logic             w_int_or;
  logic [DW-1:0]    w_rdat;
  logic             w_unused_din;

  logic [3:0]       r_ipg;
  logic [EW-1:0]    r_int_stat;
  logic [EW-1:0]    r_int_mask;
  logic             r_rd_q;
  logic [DW-1:0]    r_rdat_q;
  logic [DW-1:0]    r_dout;
  logic             r_or_d;
  logic             r_int;

  // Upper write-data bits are not backed by any register
  assign w_unused_din = ^cpu_din;

  // Address decode
  assign w_wr       = cpu_cs & cpu_wr;
  assign w_rd       = cpu_cs & cpu_rd;
  assign w_sel_ver  = (cpu_addr == AW'(ADDR_VERSION));
  assign w_sel_ctrl = (cpu_addr == AW'(ADDR_CTRL));
  assign w_sel_stat = (cpu_addr == AW'(ADDR_INT_STAT));
  assign w_sel_mask = (cpu_addr == AW'(ADDR_INT_MASK));
  assign w_in_ch    = (cpu_addr >= AW'(CH_BASE));
  assign w_ch_rel   = cpu_addr - AW'(CH_BASE);
  assign w_ch_off   = w_ch_rel[1:0];

  // Per-channel register blocks; addresses beyond NCH never hit
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_ch_hit[c] = w_in_ch && (w_ch_rel[AW-1:2] == (AW-2)'(c));

    tmac_mpi_chreg #(
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
    ) u_chreg (
      .clk100m   (clk100m),
      .rst       (rst),
      .i_wr_ctrl (w_wr && w_ch_hit[c] && (w_ch_off == CH_OFF_CTRL)),
      .i_wr_len  (w_wr && w_ch_hit[c] && (w_ch_off == CH_OFF_LEN)),
      .i_wr_cnt  (w_wr && w_ch_hit[c] && (w_ch_off == CH_OFF_CNT)),
      .i_wdat    (cpu_din[LEN_W-1:0]),
      .i_pkt_ind (pkt_ind[c]),
      .o_rdi_en  (w_rdi[c]),
      .o_rtp_en  (w_rtp[c]),
      .o_pkt_com (w_com[c]),
      .o_len     (w_len[c]),
      .o_cnt     (w_cnt[c])
    );

    assign tpkt_length[c*LEN_W +: LEN_W] = w_len[c];
  end

  // Read mux works on pre-write state, so a same-cycle read/write returns the old value
  always_comb begin
    w_rdat = '0;
    if (w_sel_ver) begin
      w_rdat = DW'(VERSION);
    end else if (w_sel_ctrl) begin
      w_rdat[3:0] = r_ipg;
    end else if (w_sel_stat) begin
      w_rdat[EW-1:0] = r_int_stat;
    end else if (w_sel_mask) begin
      w_rdat[EW-1:0] = r_int_mask;
    end
    for (int c = 0; c < NCH; c++) begin
      if (w_ch_hit[c]) begin
        case (w_ch_off)
          CH_OFF_CTRL: w_rdat[2:0]       = {w_com[c], w_rtp[c], w_rdi[c]};
          CH_OFF_LEN:  w_rdat[LEN_W-1:0] = w_len[c];
          CH_OFF_CNT:  w_rdat[CNT_W-1:0] = w_cnt[c];
          default:     w_rdat            = '0;
        endcase
      end
    end
  end

  assign w_clr    = (w_wr && w_sel_stat) ? cpu_din[EW-1:0] : '0;
  assign w_int_or = |(r_int_stat & r_int_mask);

  always_ff @(posedge clk100m) begin
    if (!rst) begin
      r_ipg      <= 4'(IPG_RST);
      r_int_stat <= '0;
      r_int_mask <= '0;
      r_rd_q     <= 1'b0;
      r_rdat_q   <= '0;
      r_dout     <= '0;
      r_or_d     <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      if (w_wr && w_sel_ctrl) begin
        r_ipg <= cpu_din[3:0];
      end
      if (w_wr && w_sel_mask) begin
        r_int_mask <= cpu_din[EW-1:0];
      end
      // New events override a coincident W1C so nothing is missed
      r_int_stat <= (r_int_stat & ~w_clr) | fifo_evt;

      // Read data is captured at the strobe edge, then presented one edge later
      r_rd_q <= w_rd;
      if (w_rd) begin
        r_rdat_q <= w_rdat;
      end
      if (r_rd_q) begin
        r_dout <= r_rdat_q;
      end

      r_or_d <= w_int_or;
      r_int  <= (INT_PULSE != 0) ? (w_int_or & ~r_or_d) : w_int_or;
    end
  end

  assign cpu_dout = r_dout;
  assign cpu_int  = r_int;
  assign ipg_th   = r_ipg;
  assign rdi_en   = w_rdi;
  assign rtp_en   = w_rtp;
  assign pkt_com  = w_com;

endmodule

// File: doc/tmac_mpi_nch.md
Name: tmac_mpi_nch

Overview:
Parametrised CPU register interface for the transmit MAC, generalising the fixed three-channel MPI to NCH channels.
- Holds global IPG threshold, per-channel enables, transmit packet length, packet-complete handshake and saturating packet counters.
- Collects per-channel FIFO overflow/underflow events into a sticky, maskable interrupt status register with write-1-to-clear.
- Sits between the CPU bus (clk100m domain) and the per-channel TMAC datapaths. All datapath inputs are already synchronous to clk100m.

Parameters:
NCH, 3, number of transmit channels (1..4; 4*NCH <= DW)
AW, 8, CPU word-address width
DW, 16, CPU data width
LEN_W, 10, tpkt_length width (<= DW)
IPG_RST, 12, reset value of ipg_th
INT_PULSE, 0, 0 = level interrupt; 1 = one-cycle pulse on each 0->1 of the masked-OR

Ports:
clk100m  in  1  sole clock
rst  in  1  synchronous reset, active low
cpu_cs  in  1  chip select
cpu_wr  in  1  write strobe (valid with cpu_cs)
cpu_rd  in  1  read strobe (valid with cpu_cs)
cpu_addr  in  AW  word address
cpu_din  in  DW  write data
cpu_dout  out  DW  read data, registered
cpu_int  out  1  interrupt
pkt_ind  in  NCH  per-channel "packet taken" pulse/level from datapath
fifo_evt  in  4*NCH  per channel c, bits [4c+3:4c] = {tmac_udf, tmac_ovf, bm_udf, bm_ovf}
ipg_th  out  4  inter-packet gap threshold
rdi_en  out  NCH  per-channel RDI enable
rtp_en  out  NCH  per-channel RTP enable
pkt_com  out  NCH  per-channel packet-complete flag
tpkt_length  out  NCH*LEN_W  per-channel length, channel c at [c*LEN_W +: LEN_W]

Behaviour:
- Reset (rst=0 at clk100m edge):
  - cpu_dout=0, cpu_int=0, ipg_th=IPG_RST.
  - All per-channel registers, int_stat, int_mask and counters = 0.
  - Reset mid-operation aborts everything, including a pending read.
- Register map (word addresses). Unmapped or nonexistent-channel addresses read 0; writes to them are ignored.
  - 0x00 VERSION: RO, constant 16'h0201.
  - 0x01 CTRL: [3:0] ipg_th, RW.
  - 0x02 INT_STAT: [4*NCH-1:0] sticky, W1C.
  - 0x03 INT_MASK: [4*NCH-1:0], RW; 1 = enabled.
  - 0x10+4c CH_CTRL: bit0 rdi_en, bit1 rtp_en, RW; bit2 pkt_com, write 1 sets, write 0 no effect, readable.
  - 0x11+4c TPKT_LEN: [LEN_W-1:0], RW; upper bits read 0.
  - 0x12+4c PKT_CNT: RO value; any write clears it to 0.
- Write: takes effect at the edge where cpu_cs & cpu_wr. The new value is visible on outputs the next cycle.
- Read: cpu_cs & cpu_rd at edge N -> cpu_dout valid after edge N+1 (1-cycle latency). cpu_dout holds its value until the next read.
  - Read and write to the same address in the same cycle: returns the pre-write value.
- pkt_ind handling:
  - Registered once internally; a rising edge is detected as pkt_ind & ~pkt_ind_d.
  - A rising edge clears pkt_com[c] and increments PKT_CNT[c]. The counter saturates at 16'hFFFF with no wrap.
  - Same cycle as a CPU write of pkt_com=1: set wins; the counter still increments.
  - Same cycle as a PKT_CNT write: the clear wins; the counter becomes 0.
- Interrupt status:
  - int_stat[i] is set whenever fifo_evt[i]=1, regardless of mask.
  - It is cleared by a W1C write with cpu_din[i]=1.
  - Simultaneous set and clear: set wins.
- cpu_int:
  - INT_PULSE=0: registered |(int_stat & int_mask), one cycle after the status/mask change.
  - INT_PULSE=1: one-cycle high when that OR goes 0->1. No re-fire while it stays 1.

Decomposition:
- Shared package tmac_pkg holds:
  - Register offsets (ADDR_VERSION, ADDR_CTRL, ADDR_INT_STAT, ADDR_INT_MASK, CH_BASE=0x10, CH_STRIDE=4, CH_CTRL/LEN/CNT offsets).
  - VERSION constant.
  - Event bit indices EVT_BM_OVF=0, EVT_BM_UDF=1, EVT_TMAC_OVF=2, EVT_TMAC_UDF=3.
- Sub-module tmac_mpi_chreg, generated NCH times. It holds one channel's CH_CTRL, TPKT_LEN, pkt_ind edge detect and saturating PKT_CNT.
- The top level holds address decode, the global registers, interrupt logic and the read mux.

Test Plan:
- Reset values: after reset, read 0x00 -> 16'h0201; read 0x01 -> 16'h000C; read 0x02, 0x03, 0x10, 0x11, 0x12 -> 0; cpu_int=0.
- Read latency and hazard: write 0x11 = 16'hFFFF -> tpkt_length[9:0]=10'h3FF next cycle; read 0x11 -> 16'h03FF exactly one cycle after the strobe. Same-cycle write 0x01=5 with read of 0x01 -> returns 12, and ipg_th=5 after.
- pkt_com handshake: write 0x14 = 16'h0004 -> pkt_com[1]=1. Pulse pkt_ind[1] -> pkt_com[1]=0 and read 0x16 -> 1. Write pkt_com and raise pkt_ind[1] in the same cycle -> pkt_com[1]=1 and PKT_CNT=2.
- Counter saturation and clear: issue 65537 rising edges on pkt_ind[0] -> read 0x12 = 16'hFFFF. Write 0x12 together with a rising edge -> 0.
- Interrupt: with mask 0, pulse fifo_evt[6] (ch1 tmac_ovf) -> INT_STAT = 16'h0040 and cpu_int=0. Write mask 16'h0040 -> cpu_int=1 one cycle later. W1C 16'h0040 in the same cycle as a new fifo_evt[6] -> bit stays 1. A later W1C alone -> INT_STAT=0, cpu_int=0.
- INT_PULSE=1 build: two successive events on the same enabled bit without a clear -> exactly one cpu_int pulse. Clear then a new event -> a second one-cycle pulse.
